// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared opcodes, state encodings and ALU codes for the multicycle controller
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_FUNCT = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - maps internal aluop and R-type funct to the datapath ALU control code
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        funct_illegal
);

    // ALU code selection; unknown funct keeps add and raises the illegal flag
    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller_ext.sv
// rtl/mc_controller_ext.sv - multicycle MIPS control FSM with memory wait states and extended ops
module mc_controller_ext
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit MEM_HS    = 1'b1,
    parameter bit EXT_OPS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic                 regdst,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 pcen,
    output logic                 extop,
    output logic                 illegal,
    output logic [3:0]           state_dbg
);

    state_t     state;
    state_t     next_state;
    state_t     cur;
    aluop_t     aluop;
    logic       rdy;
    logic [2:0] alu3;
    logic       funct_illegal;
    logic       pcwrite;
    logic       beq_st;
    logic       bne_st;
    logic       mw_raw;
    logic       irw_raw;
    logic       rw_raw;
    logic       ill_raw;

    // With the handshake disabled every access completes in one cycle
    assign rdy = MEM_HS ? mem_ready : 1'b1;

    // Outputs follow FETCH while reset is held, whatever the register holds
    assign cur       = reset ? S_FETCH : state;
    assign state_dbg = state;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ALU operation class per state; immediate ops are split by opcode held in IR
    always_comb begin
        aluop = ALUOP_ADD;
        case (cur)
            S_RTYPEEX:        aluop = ALUOP_FUNCT;
            S_BEQEX, S_BNEEX: aluop = ALUOP_SUB;
            S_IMMEX: begin
                case (op)
                    OP_ANDI: aluop = ALUOP_AND;
                    OP_ORI:  aluop = ALUOP_OR;
                    OP_SLTI: aluop = ALUOP_SLT;
                    default: aluop = ALUOP_ADD;
                endcase
            end
            default: aluop = ALUOP_ADD;
        endcase
    end

    mc_aludec u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alu3),
        .funct_illegal (funct_illegal)
    );

    // Zero-extends the 3-bit code into whatever width the datapath expects
    always_comb begin
        alucontrol      = '0;
        alucontrol[2:0] = alu3;
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state = S_FETCH;
        iord       = 1'b0;
        mw_raw     = 1'b0;
        irw_raw    = 1'b0;
        memtoreg   = 1'b0;
        rw_raw     = 1'b0;
        alusrca    = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        extop      = 1'b1;
        pcwrite    = 1'b0;
        beq_st     = 1'b0;
        bne_st     = 1'b0;
        ill_raw    = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irw_raw    = rdy;
                pcwrite    = rdy;
                next_state = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_IMMEX;
                    OP_J:         next_state = S_JEX;
                    OP_BNE: begin
                        if (EXT_OPS) next_state = S_BNEEX;
                        else         ill_raw    = 1'b1;
                    end
                    OP_ANDI, OP_ORI, OP_SLTI: begin
                        if (EXT_OPS) next_state = S_IMMEX;
                        else         ill_raw    = 1'b1;
                    end
                    default: ill_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                rw_raw   = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mw_raw     = 1'b1;
                next_state = rdy ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                // An unknown funct aborts before write-back so no register is clobbered
                if (funct_illegal) ill_raw    = 1'b1;
                else               next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst = 1'b1;
                rw_raw = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                beq_st  = 1'b1;
            end
            S_BNEEX: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                bne_st  = 1'b1;
            end
            S_IMMEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                extop      = !((op == OP_ANDI) || (op == OP_ORI));
                next_state = S_IMMWB;
            end
            S_IMMWB: begin
                rw_raw = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Write strobes and the illegal pulse are suppressed in any reset cycle
    assign memwrite = mw_raw  & ~reset;
    assign irwrite  = irw_raw & ~reset;
    assign regwrite = rw_raw  & ~reset;
    assign illegal  = ill_raw & ~reset;
    assign pcen     = (pcwrite | (beq_st & zero) | (bne_st & ~zero)) & ~reset;

endmodule

// File: tb/tb_mc_controller_ext.sv
// tb/tb_mc_controller_ext.sv - directed self-checking bench for mc_controller_ext
module tb_mc_controller_ext;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, memtoreg, regwrite, alusrca, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, extop, illegal;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // {state, iord memwrite irwrite memtoreg regwrite alusrca regdst, alusrcb, pcsrc, alucontrol, pcen extop illegal}
    localparam logic [20:0] V_FETCH  = {4'd0,  7'b0010000, 2'b01, 2'b00, 3'b010, 3'b110};
    localparam logic [20:0] V_STALL  = {4'd0,  7'b0000000, 2'b01, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_DEC    = {4'd1,  7'b0000000, 2'b11, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_DECILL = {4'd1,  7'b0000000, 2'b11, 2'b00, 3'b010, 3'b011};
    localparam logic [20:0] V_MA     = {4'd2,  7'b0000010, 2'b10, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_MR     = {4'd3,  7'b1000000, 2'b00, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_MWB    = {4'd4,  7'b0001100, 2'b00, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_MW     = {4'd5,  7'b1100000, 2'b00, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_MWRST  = {4'd5,  7'b0000000, 2'b01, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_RWB    = {4'd7,  7'b0000101, 2'b00, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_IWB    = {4'd11, 7'b0000100, 2'b00, 2'b00, 3'b010, 3'b010};
    localparam logic [20:0] V_J      = {4'd12, 7'b0000000, 2'b00, 2'b10, 3'b010, 3'b110};

    mc_controller_ext dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .regdst     (regdst),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .extop      (extop),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {state_dbg, iord, memwrite, irwrite, memtoreg, regwrite, alusrca, regdst,
                alusrcb, pcsrc, alucontrol, pcen, extop, illegal};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic test_reset();
        reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (obs() !== V_STALL) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs(), V_STALL); end
        reset = 1'b0; #1;
        checks++;
        if (obs() !== V_FETCH) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs(), V_FETCH); end
    endtask

    task automatic test_lw();
        logic [20:0] e[$];
        e = '{V_FETCH, V_DEC, V_MA, V_MR, V_MWB, V_FETCH};
        op = 6'b100011; mem_ready = 1'b1;
        foreach (e[i]) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL lw[%0d] got=%h exp=%h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_fetch_wait();
        logic [20:0] e[$];
        logic        r[$];
        e = '{V_STALL, V_STALL, V_FETCH, V_DEC, V_J, V_FETCH};
        r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op = 6'b000010;
        foreach (e[i]) begin
            if (i > 0) @(negedge clk);
            mem_ready = r[i]; #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL fetch_wait_j[%0d] got=%h exp=%h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_sw_wait();
        logic [20:0] e[$];
        logic        r[$];
        e = '{V_FETCH, V_DEC, V_MA, V_MW, V_MW, V_MW, V_MW, V_FETCH};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 6'b101011;
        foreach (e[i]) begin
            if (i > 0) @(negedge clk);
            mem_ready = r[i]; #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL sw_wait[%0d] got=%h exp=%h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops[4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic        zs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        pe[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  st[4]  = '{4'd8, 4'd8, 4'd9, 4'd9};
        logic [20:0] e[3];
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = ops[k]; zero = zs[k];
            e[0] = V_DEC;
            e[1] = {st[k], 7'b0000010, 2'b00, 2'b01, 3'b110, pe[k], 1'b1, 1'b0};
            e[2] = V_FETCH;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); #1;
                checks++;
                if (obs() !== e[i]) begin errors++; $display("FAIL branch%0d[%0d] got=%h exp=%h", k, i, obs(), e[i]); end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0]  fn[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        logic [2:0]  ac[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        logic [20:0] e[$];
        op = 6'b000000; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            funct = fn[k];
            if (k < 5)
                e = '{V_DEC, {4'd6, 7'b0000010, 2'b00, 2'b00, ac[k], 3'b010}, V_RWB, V_FETCH};
            else
                e = '{V_DEC, {4'd6, 7'b0000010, 2'b00, 2'b00, ac[k], 3'b011}, V_FETCH};
            foreach (e[i]) begin
                @(negedge clk); #1;
                checks++;
                if (obs() !== e[i]) begin errors++; $display("FAIL rtype%0d[%0d] got=%h exp=%h", k, i, obs(), e[i]); end
            end
        end
    endtask

    task automatic test_imm();
        logic [5:0]  ops[4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
        logic [2:0]  ac[4]  = '{3'b010, 3'b000, 3'b001, 3'b111};
        logic        ex[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [20:0] e[4];
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op = ops[k];
            e[0] = V_DEC;
            e[1] = {4'd10, 7'b0000010, 2'b10, 2'b00, ac[k], 1'b0, ex[k], 1'b0};
            e[2] = V_IWB;
            e[3] = V_FETCH;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); #1;
                checks++;
                if (obs() !== e[i]) begin errors++; $display("FAIL imm%0d[%0d] got=%h exp=%h", k, i, obs(), e[i]); end
            end
        end
    endtask

    task automatic test_illegal_op();
        logic [20:0] e[2];
        e = '{V_DECILL, V_FETCH};
        op = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL illegal_op[%0d] got=%h exp=%h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] e[$];
        e = '{V_DEC, V_MA, V_MW};
        op = 6'b101011; mem_ready = 1'b1;
        foreach (e[i]) begin
            @(negedge clk);
            if (i == 2) mem_ready = 1'b0;
            #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL rstmid_pre[%0d] got=%h exp=%h", i, obs(), e[i]); end
        end
        reset = 1'b1; #1;
        checks++;
        if (obs() !== V_MWRST) begin errors++; $display("FAIL rstmid_in_reset got=%h exp=%h", obs(), V_MWRST); end
        @(negedge clk);
        reset = 1'b0; #1;
        checks++;
        if (obs() !== V_STALL) begin errors++; $display("FAIL rstmid_after got=%h exp=%h", obs(), V_STALL); end
        mem_ready = 1'b1; #1;
        checks++;
        if (obs() !== V_FETCH) begin errors++; $display("FAIL rstmid_fetch got=%h exp=%h", obs(), V_FETCH); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_wait();
        test_sw_wait();
        test_branch();
        test_rtype();
        test_imm();
        test_illegal_op();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
